// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings, opcodes and the issue-entry payload
// used by the decoder, the issue stage and the EX stage.
package alu_pkg;

    localparam int PL_XLEN   = 32;
    localparam int PL_CTRL_W = 4;
    localparam int PL_RD_W   = 5;
    localparam int PL_F3_W   = 3;

    localparam logic [PL_CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [PL_CTRL_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [PL_CTRL_W-1:0] ALU_SLL  = 4'b0001;
    localparam logic [PL_CTRL_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [PL_CTRL_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [PL_CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [PL_CTRL_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [PL_CTRL_W-1:0] ALU_SRA  = 4'b1101;
    localparam logic [PL_CTRL_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [PL_CTRL_W-1:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [PL_XLEN-1:0]   a;
        logic [PL_XLEN-1:0]   b;
        logic [PL_CTRL_W-1:0] ctrl;
        logic [PL_RD_W-1:0]   rd;
        logic [PL_XLEN-1:0]   pc;
        logic [PL_F3_W-1:0]   funct3;
        logic                 is_branch;
        logic                 illegal;
    } issue_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID->EX issue bus: decoded-instruction input handshake, forwarding tap, flush,
// and the operand/control output handshake toward EX.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [PL_XLEN-1:0]   in_pc;
    logic [31:0]          in_instr;
    logic [PL_XLEN-1:0]   in_rs1_data;
    logic [PL_XLEN-1:0]   in_rs2_data;
    logic [PL_XLEN-1:0]   in_imm;
    logic                 fwd_valid;
    logic [PL_RD_W-1:0]   fwd_rd;
    logic [PL_XLEN-1:0]   fwd_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [PL_XLEN-1:0]   out_a;
    logic [PL_XLEN-1:0]   out_b;
    logic [PL_CTRL_W-1:0] out_alu_ctrl;
    logic [PL_RD_W-1:0]   out_rd;
    logic [PL_XLEN-1:0]   out_pc;
    logic [PL_F3_W-1:0]   out_funct3;
    logic                 out_is_branch;
    logic                 out_illegal;

    modport master (
        output flush, in_valid, in_pc, in_instr, in_rs1_data, in_rs2_data, in_imm,
               fwd_valid, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_pc,
               out_funct3, out_is_branch, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, in_rs1_data, in_rs2_data, in_imm,
               fwd_valid, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_pc,
               out_funct3, out_is_branch, out_illegal
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of one instruction into ALU operands, alu_ctrl and
// writeback/branch/illegal side information.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0]        instr,
    input  logic [PL_XLEN-1:0] pc,
    input  logic [PL_XLEN-1:0] rs1,
    input  logic [PL_XLEN-1:0] rs2,
    input  logic [PL_XLEN-1:0] imm,
    output issue_t             pl
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       unused_bits;

    assign opc         = instr[6:0];
    assign f3          = instr[14:12];
    assign unused_bits = ^{instr[31], instr[29:15]};

    always_comb begin
        pl           = '0;
        pl.pc        = pc;
        pl.funct3    = f3;
        pl.rd        = instr[11:7];
        pl.ctrl      = ALU_ADD;
        case (opc)
            OPC_OP: begin
                pl.a    = rs1;
                pl.b    = rs2;
                pl.ctrl = {instr[30], f3};
            end
            OPC_OPIMM: begin
                // instr[30] is immediate bits for everything but the right shifts
                pl.a    = rs1;
                pl.b    = imm;
                pl.ctrl = {(f3 == 3'b101) & instr[30], f3};
            end
            OPC_LUI: begin
                pl.b = imm;
            end
            OPC_AUIPC: begin
                pl.a = pc;
                pl.b = imm;
            end
            OPC_LOAD: begin
                pl.a = rs1;
                pl.b = imm;
            end
            OPC_STORE: begin
                pl.a  = rs1;
                pl.b  = imm;
                pl.rd = '0;
            end
            OPC_JAL, OPC_JALR: begin
                pl.a = pc;
                pl.b = PL_XLEN'(4);
            end
            OPC_BRANCH: begin
                pl.a         = rs1;
                pl.b         = rs2;
                pl.rd        = '0;
                pl.is_branch = 1'b1;
                pl.ctrl      = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            default: begin
                pl.illegal = 1'b1;
                pl.rd      = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register with a 2-entry skid buffer (head + skid) and optional
// operand forwarding at accept, enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input logic clk,
    input logic rst_n,
    alu_issue_stage_if.slave bus
);

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    issue_t          dec_pl;
    issue_t          head_q;
    issue_t          skid_q;
    logic            head_vld;
    logic            skid_vld;
    logic            accept;
    logic            pop;

`ifdef ALU_ISSUE_FWD_EN
    logic fwd_hit1;
    logic fwd_hit2;

    assign fwd_hit1 = bus.fwd_valid && (bus.fwd_rd != '0) && (bus.fwd_rd == bus.in_instr[19:15]);
    assign fwd_hit2 = bus.fwd_valid && (bus.fwd_rd != '0) && (bus.fwd_rd == bus.in_instr[24:20]);
    assign rs1_val  = fwd_hit1 ? bus.fwd_data : bus.in_rs1_data;
    assign rs2_val  = fwd_hit2 ? bus.fwd_data : bus.in_rs2_data;
`else
    logic unused_fwd;

    assign unused_fwd = ^{bus.fwd_valid, bus.fwd_rd, bus.fwd_data};
    assign rs1_val    = bus.in_rs1_data;
    assign rs2_val    = bus.in_rs2_data;
`endif

    alu_op_decode u_dec (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .rs1   (rs1_val),
        .rs2   (rs2_val),
        .imm   (bus.in_imm),
        .pl    (dec_pl)
    );

    // ready depends only on registered state, so no comb path from out_ready
    assign bus.in_ready = ~skid_vld;
    assign accept       = bus.in_valid & ~skid_vld & ~bus.flush;
    assign pop          = head_vld & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
            head_q   <= '0;
            skid_q   <= '0;
        end else if (bus.flush) begin
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (pop && skid_vld) begin
            head_q   <= skid_q;
            skid_vld <= 1'b0;
        end else if (pop) begin
            head_vld <= accept;
            if (accept) head_q <= dec_pl;
        end else if (accept) begin
            if (!head_vld) begin
                head_q   <= dec_pl;
                head_vld <= 1'b1;
            end else begin
                skid_q   <= dec_pl;
                skid_vld <= 1'b1;
            end
        end
    end

    assign bus.out_valid     = head_vld;
    assign bus.out_a         = head_q.a;
    assign bus.out_b         = head_q.b;
    assign bus.out_alu_ctrl  = CTRL_W'(head_q.ctrl);
    assign bus.out_rd        = head_q.rd;
    assign bus.out_pc        = head_q.pc;
    assign bus.out_funct3    = head_q.funct3;
    assign bus.out_is_branch = head_q.is_branch;
    assign bus.out_illegal   = head_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode vector table, skid/flush/reset/forwarding
// sequences, then random traffic against a queue-based reference model.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_stage_if bus();

    alu_issue_stage #(.XLEN(32), .CTRL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr, pc, rs1, rs2, imm, a, b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        br, il;
        string       nm;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic issue_t observe();
        issue_t o;
        o.a = bus.out_a; o.b = bus.out_b; o.ctrl = bus.out_alu_ctrl; o.rd = bus.out_rd;
        o.pc = bus.out_pc; o.funct3 = bus.out_funct3;
        o.is_branch = bus.out_is_branch; o.illegal = bus.out_illegal;
        return o;
    endfunction

    // Reference decode straight from the instruction-class rules
    function automatic issue_t ref_decode(input logic [31:0] instr, pc, rs1d, rs2d, imm,
                                          input logic fv, input logic [4:0] frd,
                                          input logic [31:0] fd);
        issue_t e;
        logic [31:0] s1, s2;
        logic [2:0] f3;
        logic [6:0] op;
        logic wb;
        f3 = instr[14:12];
        op = instr[6:0];
        s1 = rs1d;
        s2 = rs2d;
`ifdef ALU_ISSUE_FWD_EN
        if (fv && frd != 0 && frd == instr[19:15]) s1 = fd;
        if (fv && frd != 0 && frd == instr[24:20]) s2 = fd;
`endif
        e = '0;
        e.pc = pc;
        e.funct3 = f3;
        wb = 1'b1;
        if (op == 7'h33) begin e.a = s1; e.b = s2; e.ctrl = {instr[30], f3}; end
        else if (op == 7'h13) begin
            e.a = s1; e.b = imm;
            e.ctrl = (f3 == 3'd5) ? {instr[30], f3} : {1'b0, f3};
        end
        else if (op == 7'h37) begin e.a = 0; e.b = imm; end
        else if (op == 7'h17) begin e.a = pc; e.b = imm; end
        else if (op == 7'h03) begin e.a = s1; e.b = imm; end
        else if (op == 7'h23) begin e.a = s1; e.b = imm; wb = 1'b0; end
        else if (op == 7'h6F || op == 7'h67) begin e.a = pc; e.b = 32'd4; end
        else if (op == 7'h63) begin
            e.a = s1; e.b = s2; wb = 1'b0; e.is_branch = 1'b1;
            if (f3 == 3'd4 || f3 == 3'd5) e.ctrl = 4'b0010;
            else if (f3 == 3'd6 || f3 == 3'd7) e.ctrl = 4'b0011;
            else e.ctrl = 4'b1000;
        end
        else begin e.illegal = 1'b1; wb = 1'b0; end
        e.rd = wb ? instr[11:7] : 5'd0;
        return e;
    endfunction

    task automatic put(input logic [31:0] instr, pc, rs1d, rs2d, imm);
        bus.in_valid = 1'b1; bus.in_instr = instr; bus.in_pc = pc;
        bus.in_rs1_data = rs1d; bus.in_rs2_data = rs2d; bus.in_imm = imm;
    endtask

    task automatic fill_two(input logic [31:0] ta, input logic [31:0] tb);
        @(negedge clk);
        bus.out_ready = 1'b0;
        put(32'h002081B3, 32'h300, ta, 1, 0);
        @(negedge clk);
        put(32'h002081B3, 32'h304, tb, 1, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        issue_t q[$];
        issue_t exp;
        logic [31:0] got[$];
        logic [31:0] ins;
        logic acc, pop;
        logic [6:0] opcs[11];

        rst_n = 1'b0;
        bus.flush = 0; bus.in_valid = 0; bus.in_pc = 0; bus.in_instr = 0;
        bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0;
        bus.fwd_valid = 0; bus.fwd_rd = 0; bus.fwd_data = 0; bus.out_ready = 1;

        tbl[0]  = '{32'h40208033, 32'h100, 5, 3, 0, 5, 3, 4'h8, 0, 0, 0, "sub"};
        tbl[1]  = '{32'h002081B3, 32'h104, 5, 3, 0, 5, 3, 4'h0, 3, 0, 0, "add"};
        tbl[2]  = '{32'h4010D093, 32'h108, 32'h80000000, 3, 32'h401, 32'h80000000, 32'h401, 4'hD, 1, 0, 0, "srai"};
        tbl[3]  = '{32'h0010D093, 32'h10C, 32'h80000000, 3, 32'h1, 32'h80000000, 32'h1, 4'h5, 1, 0, 0, "srli"};
        tbl[4]  = '{32'h40008093, 32'h110, 7, 3, 32'h400, 7, 32'h400, 4'h0, 1, 0, 0, "addi_b30"};
        tbl[5]  = '{32'h123452B7, 32'h114, 7, 3, 32'h12345000, 0, 32'h12345000, 4'h0, 5, 0, 0, "lui"};
        tbl[6]  = '{32'h00001517, 32'h100, 7, 3, 32'h1000, 32'h100, 32'h1000, 4'h0, 10, 0, 0, "auipc"};
        tbl[7]  = '{32'h008000EF, 32'h200, 7, 3, 32'h8, 32'h200, 4, 4'h0, 1, 0, 0, "jal"};
        tbl[8]  = '{32'h0020C463, 32'h204, 9, 3, 32'h8, 9, 3, 4'h2, 0, 1, 0, "blt"};
        tbl[9]  = '{32'h0020F463, 32'h208, 9, 3, 32'h8, 9, 3, 4'h3, 0, 1, 0, "bgeu"};
        tbl[10] = '{32'h0020A423, 32'h20C, 9, 3, 32'h8, 9, 32'h8, 4'h0, 0, 0, 0, "sw"};
        tbl[11] = '{32'h00000FFF, 32'h210, 9, 3, 32'h8, 0, 0, 4'h0, 0, 0, 1, "illegal"};
        tbl[12] = '{32'h0000A083, 32'h214, 9, 3, 32'hFFFFFFF0, 9, 32'hFFFFFFF0, 4'h0, 1, 0, 0, "lw"};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_payload", observe(), '0);
        rst_n = 1'b1;

        // decode table, one instruction per cycle with EX always ready
        foreach (tbl[i]) begin
            @(negedge clk);
            put(tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            exp = '{tbl[i].a, tbl[i].b, tbl[i].ctrl, tbl[i].rd, tbl[i].pc,
                    tbl[i].instr[14:12], tbl[i].br, tbl[i].il};
            chk({"vld_", tbl[i].nm}, bus.out_valid, 1);
            chk({"dec_", tbl[i].nm}, observe(), exp);
        end
        @(negedge clk);
        chk("drained", bus.out_valid, 0);

        // backpressure: two accepted, ready drops, order kept on release
        fill_two(32'h111, 32'h222);
        chk("bp_in_ready_drop", bus.in_ready, 0);
        repeat (3) begin
            chk("bp_head_stable", bus.out_a, 32'h111);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (bus.out_valid) got.push_back(bus.out_a);
            @(negedge clk);
        end
        chk("bp_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("bp_first", got[0], 32'h111);
            chk("bp_second", got[1], 32'h222);
        end

        // flush with both entries full and a same-cycle input
        fill_two(32'h333, 32'h444);
        bus.flush = 1'b1;
        put(32'h002081B3, 32'h308, 32'h555, 1, 0);
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("flush_nothing_kept", bus.out_valid, 0);
        // flush with only head full: in_ready is 1 but the input is dropped
        bus.out_ready = 1'b0;
        put(32'h002081B3, 32'h30C, 32'h666, 1, 0);
        @(negedge clk);
        bus.flush = 1'b1;
        put(32'h002081B3, 32'h310, 32'h777, 1, 0);
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_head_only", bus.out_valid, 0);
        bus.out_ready = 1'b1;

        // forwarding
        @(negedge clk);
        put(32'h002380B3, 32'h400, 0, 5, 0);
        bus.fwd_valid = 1'b1; bus.fwd_rd = 5'd7; bus.fwd_data = 32'hDEADBEEF;
        @(negedge clk);
        bus.in_valid = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_rs1", bus.out_a, 32'hDEADBEEF);
`else
        chk("fwd_rs1", bus.out_a, 32'h0);
`endif
        chk("fwd_rs1_b", bus.out_b, 32'h5);
        put(32'h002380B3, 32'h404, 32'h11, 32'h22, 0);
        bus.fwd_rd = 5'd2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("fwd_rs2_a", bus.out_a, 32'h11);
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_rs2_b", bus.out_b, 32'hDEADBEEF);
`else
        chk("fwd_rs2_b", bus.out_b, 32'h22);
`endif
        put(32'h002000B3, 32'h408, 32'h55, 32'h66, 0);
        bus.fwd_rd = 5'd0;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.fwd_valid = 1'b0;
        chk("fwd_x0_ignored", bus.out_a, 32'h55);

        // reset mid-stream with both entries full
        fill_two(32'h888, 32'h999);
        chk("pre_rst_full", bus.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_ctrl", bus.out_alu_ctrl, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic against the queue model
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63, 7'h7F, 7'h0B};
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            chk("rnd_in_ready", bus.in_ready, q.size() < 2);
            chk("rnd_out_valid", bus.out_valid, q.size() > 0);
            if (q.size() > 0) chk("rnd_payload", observe(), q[0]);
            ins = $urandom;
            ins[6:0] = opcs[$urandom_range(0, 10)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            put(ins, $urandom, $urandom, $urandom, $urandom);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 24) == 0);
            bus.fwd_valid = $urandom_range(0, 1);
            bus.fwd_rd    = 5'($urandom_range(0, 7));
            bus.fwd_data  = $urandom;
            acc = bus.in_valid && (q.size() < 2) && !bus.flush;
            pop = (q.size() > 0) && bus.out_ready;
            exp = ref_decode(bus.in_instr, bus.in_pc, bus.in_rs1_data, bus.in_rs2_data,
                             bus.in_imm, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
            @(posedge clk);
            if (bus.flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(exp);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
